// File: rtl/counter_pkg.sv
// Shared types and constants for the binary counter family.
// Prescaler width sizing lives here so every counter stage agrees on it.
package counter_pkg;

    localparam logic [7:0] WRAP_SAT = 8'hFF;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } dir_t;

    // Bits needed to hold 0..prescale-1, never less than one.
    function automatic int pre_w(input int prescale);
        int w;
        w = $clog2(prescale);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled clocks down to one tick every PRESCALE enabled edges.
// The phase freezes while en is low and clears on clr.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic res,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int               PRE_W   = pre_w(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_reg;
    logic [PRE_W-1:0] pre_next;

    always_comb begin
        pre_next = pre_reg;
        if (clr) begin
            pre_next = '0;
        end else if (en) begin
            pre_next = (pre_reg == PRE_MAX) ? '0 : pre_reg + PRE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_next;
        end
    end

    // With PRESCALE=1 PRE_MAX is 0 and pre_reg never leaves 0, so tick follows en.
    assign tick = en && (pre_reg == PRE_MAX);

endmodule

// File: rtl/binary_updown_counter.sv
// Modulo-N up/down counter with prescaler, parallel load, terminal-count
// pulse and a saturating rollover tally.
module binary_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic [7:0]       wraps
);

    // Compares run one bit wider so MODULUS = 2^WIDTH stays representable.
    localparam logic [WIDTH:0]   MOD_TOP = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    logic             step;
    logic             wrap;
    dir_t             dir;
    logic [WIDTH:0]   inc_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             tc_reg, tc_next;
    logic [7:0]       wraps_reg, wraps_next;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .res  (res),
        .clr  (load),
        .en   (en),
        .tick (step)
    );

    assign dir = dir_t'(up);

    always_comb begin
        inc_ext    = {1'b0, count_reg} + (WIDTH + 1)'(1);
        load_ext   = {1'b0, load_val};
        count_next = count_reg;
        tc_next    = 1'b0;
        wraps_next = wraps_reg;
        wrap       = 1'b0;

        if (load) begin
            count_next = (load_ext > MOD_TOP) ? MAX_CNT : load_val;
        end else if (step) begin
            if (dir == UP) begin
                if (inc_ext > MOD_TOP) begin
                    count_next = '0;
                    wrap       = 1'b1;
                end else begin
                    count_next = inc_ext[WIDTH-1:0];
                end
            end else begin
                if (count_reg == '0) begin
                    count_next = MAX_CNT;
                    wrap       = 1'b1;
                end else begin
                    count_next = count_reg - WIDTH'(1);
                end
            end
        end

        if (wrap) begin
            tc_next = 1'b1;
            if (wraps_reg != WRAP_SAT) begin
                wraps_next = wraps_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            count_reg <= '0;
            tc_reg    <= 1'b0;
            wraps_reg <= '0;
        end else begin
            count_reg <= count_next;
            tc_reg    <= tc_next;
            wraps_reg <= wraps_next;
        end
    end

    assign count = count_reg;
    assign tc    = tc_reg;
    assign wraps = wraps_reg;

endmodule
